stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit registered stream multiplexer. It is the sequential successor of the 4:1 combinational Mux.
- Each input channel has a valid/ready handshake. One registered output stream is produced.
- Two selection modes:
  - Fixed: the channel index comes from port s.
  - Round-robin: arbitration among valid channels, with an optional burst lock.
- Sits between multiple producers and a single consumer in the datapath.

Parameters:
N, 4, number of input channels (2..16)
WIDTH, 8, data width per channel
BURST, 2, max consecutive beats a channel keeps the grant in round-robin mode (>=1)
SEL_W, 2, index width = clog2(N); must satisfy 2**SEL_W >= N

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select via s, 1 = round-robin
s  input  SEL_W  channel index in fixed mode; ignored in round-robin mode
a  input  N*WIDTH  channel data, channel i at a[i*WIDTH +: WIDTH]
a_valid  input  N  per-channel valid
a_ready  output  N  per-channel ready, at most one bit high (combinational)
z  output  WIDTH  registered output data
z_valid  output  1  output beat valid
z_ready  input  1  consumer ready
z_ch  output  SEL_W  index of the channel that supplied the current z

Behaviour:
- Reset (rst=1 at a clk edge):
  - z=0, z_valid=0, z_ch=0.
  - Round-robin pointer ptr=0, lock=0, beat counter cnt=0.
  - a_ready=0 while rst is high.
- Output register:
  - can_load = !z_valid || z_ready.
  - Grant g, with has_grant flag, is computed combinationally.
  - a_ready[g] = has_grant && can_load; all other bits 0.
- Accept:
  - Accept occurs when a_valid[g] && a_ready[g].
  - Next edge: z <= a[g], z_ch <= g, z_valid <= 1.
  - Latency from accept to z_valid is 1 cycle.
  - Full throughput: 1 beat/cycle while z_ready=1.
- Drain: z_valid && z_ready with no accept in the same cycle -> z_valid <= 0. z and z_ch hold their last values.
- Stall: z_valid && !z_ready -> z, z_ch and z_valid hold; all a_ready=0.
- Fixed mode (mode=0):
  - g = s, has_grant = (s < N) && a_valid[s].
  - s >= N -> no grant; all a_ready=0.
  - ptr, lock and cnt are held in this mode.
- Round-robin mode (mode=1), unlocked:
  - g = first i with a_valid[i]=1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
  - No valid channel -> has_grant=0.
- Round-robin mode, locked: g = the locked channel; has_grant = a_valid[g].
- Lock/count update, on each accept in round-robin mode:
  - If cnt == BURST-1: lock <= 0, cnt <= 0, ptr <= (g+1) mod N.
  - Otherwise: lock <= 1 (on channel g), cnt <= cnt+1.
  - BURST=1 -> never locks; ptr advances after every beat.
- Lock release on idle: locked, can_load=1, and a_valid[g]=0 -> lock <= 0, cnt <= 0, ptr <= (g+1) mod N. No beat is accepted that cycle.
- A lock is not released while can_load=0, because backpressure is not an idle producer.
- Wrap-around: ptr and g wrap modulo N. For non-power-of-2 N, indices >= N are never granted.
- Mode change: any edge where mode differs from its previous registered value clears lock and cnt. ptr is kept. The new mode governs grant in the same cycle mode changes.
- Simultaneous accept and drain in the same cycle: the new beat replaces the old one; z_valid stays 1.
- Reset mid-operation:
  - Any pending z beat is discarded.
  - Producers see a_ready=0 during reset.
  - First grant after reset follows the ptr=0 rules.
- Counter widths:
  - cnt is clog2(BURST)+1 bits and never exceeds BURST-1.
  - ptr is SEL_W bits.

Decomposition:
- Shared package / include file (mux_defs.vh):
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - clog2 function.
  - Default N/WIDTH/BURST constants.
- One sub-module, rr_pick:
  - Purely combinational rotating priority picker.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: idx[SEL_W], found.
  - Reusable by other arbiters.
- Top level holds:
  - output register
  - lock/cnt/ptr state
  - mode-change detect register
  - grant mux

Test Plan (N=4, WIDTH=8, BURST=2):
1. Fixed select:
   - Stimulus: mode=0, s=2, a_valid=4'b1111, a={8'h44,8'h33,8'h22,8'h11}, z_ready=1.
   - Response: a_ready=4'b0100; next cycle z=8'h33, z_ch=2, z_valid=1; z_valid stays 1 every cycle.
2. Round-robin with burst lock:
   - Stimulus: mode=1, all channels valid, z_ready=1, held for 8 cycles.
   - Response: z_ch sequence 0,0,1,1,2,2,3,3, then wraps to 0.
3. Backpressure:
   - Stimulus: z_ready=0 while z_valid=1 with z=8'h11.
   - Response: a_ready=0 on all channels; z and z_ch hold for 5 cycles. After z_ready=1, the next channel-0 beat (cnt=1) is accepted; no beat is lost or duplicated.
4. Idle release:
   - Stimulus: mode=1, only channel 1 valid for 1 beat, then a_valid[1]=0 and a_valid[3]=1.
   - Response: lock releases; ptr becomes 2; next grant goes to channel 3.
5. Out-of-range select and mode switch:
   - Stimulus: mode=0, s=3 with N=3 build → all a_ready=0 and z_valid falls after drain. Then switch mode to 1 mid-burst.
   - Response: cnt and lock are cleared; arbitration resumes from the retained ptr.
6. Reset mid-stream:
   - Stimulus: assert rst for 1 cycle while z_valid=1 with z=8'h22 and the burst is locked.
   - Response: next cycle z=0, z_valid=0, z_ch=0; the first grant afterward goes to the lowest valid channel (ptr=0).

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_BURST = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        int unsigned j;
        idx_o   = '0;
        found_o = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!found_o && req_i[j]) begin
                found_o = 1'b1;
                idx_o   = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with fixed or round-robin (burst-locked) selection.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned BURST = DEF_BURST,
    parameter int unsigned SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   s,
    input  logic [N*WIDTH-1:0] a,
    input  logic [N-1:0]       a_valid,
    output logic [N-1:0]       a_ready,
    output logic [WIDTH-1:0]   z,
    output logic               z_valid,
    input  logic               z_ready,
    output logic [SEL_W-1:0]   z_ch
);

    localparam int unsigned CNT_W = clog2(BURST) + 1;

    logic [WIDTH-1:0] z_q, z_d;
    logic             z_valid_q, z_valid_d;
    logic [SEL_W-1:0] z_ch_q, z_ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q;

    logic             mode_chg, lock_eff, can_load, accept, idle_rel;
    logic [CNT_W-1:0] cnt_eff;
    logic [SEL_W-1:0] pick_idx, g, g_next;
    logic             pick_found, g_valid, has_grant;
    logic [WIDTH-1:0] g_data;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req_i   (a_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // A mode change acts as if lock/cnt were already cleared in that same cycle.
    assign mode_chg = (mode != mode_q);
    assign lock_eff = lock_q && !mode_chg;
    assign cnt_eff  = mode_chg ? '0 : cnt_q;
    assign can_load = !z_valid_q || z_ready;

    always_comb begin
        g       = '0;
        g_valid = 1'b0;
        g_data  = '0;
        if (mode == MODE_FIXED) begin
            g = s;
        end else if (lock_eff) begin
            g = lock_ch_q;
        end else begin
            g = pick_idx;
        end
        // Loop-based select keeps out-of-range indices (s >= N) from ever matching.
        for (int unsigned i = 0; i < N; i++) begin
            if (SEL_W'(i) == g) begin
                g_valid = a_valid[i];
                g_data  = a[i*WIDTH +: WIDTH];
            end
        end
        has_grant = (mode == MODE_RR && !lock_eff) ? pick_found : g_valid;
    end

    assign g_next   = (g == SEL_W'(N - 1)) ? '0 : g + SEL_W'(1);
    assign accept   = !rst && has_grant && can_load;
    assign idle_rel = (mode == MODE_RR) && lock_eff && can_load && !g_valid;

    always_comb begin
        a_ready = '0;
        if (accept) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (SEL_W'(i) == g) begin
                    a_ready[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        z_d       = z_q;
        z_valid_d = z_valid_q;
        z_ch_d    = z_ch_q;
        ptr_d     = ptr_q;
        lock_d    = lock_eff;
        lock_ch_d = lock_ch_q;
        cnt_d     = cnt_eff;

        if (accept) begin
            z_d       = g_data;
            z_valid_d = 1'b1;
            z_ch_d    = g;
            if (mode == MODE_RR) begin
                if (cnt_eff == CNT_W'(BURST - 1)) begin
                    lock_d = 1'b0;
                    cnt_d  = '0;
                    ptr_d  = g_next;
                end else begin
                    lock_d    = 1'b1;
                    lock_ch_d = g;
                    cnt_d     = cnt_eff + CNT_W'(1);
                end
            end
        end else if (z_valid_q && z_ready) begin
            z_valid_d = 1'b0;
        end

        if (idle_rel) begin
            lock_d = 1'b0;
            cnt_d  = '0;
            ptr_d  = g_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q       <= '0;
            z_valid_q <= 1'b0;
            z_ch_q    <= '0;
            ptr_q     <= '0;
            lock_ch_q <= '0;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= MODE_FIXED;
        end else begin
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
            z_ch_q    <= z_ch_d;
            ptr_q     <= ptr_d;
            lock_ch_q <= lock_ch_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode;
        end
    end

    assign z       = z_q;
    assign z_valid = z_valid_q;
    assign z_ch    = z_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: N=4 main instance plus an N=3 instance for range checks.
module tb_stream_mux_rr;

    logic        clk;
    logic        rst;

    logic        mode;
    logic [1:0]  s;
    logic [31:0] a;
    logic [3:0]  a_valid;
    logic [3:0]  a_ready;
    logic [7:0]  z;
    logic        z_valid;
    logic        z_ready;
    logic [1:0]  z_ch;

    logic        mode3;
    logic [1:0]  s3;
    logic [23:0] a3;
    logic [2:0]  a_valid3;
    logic [2:0]  a_ready3;
    logic [7:0]  z3;
    logic        z_valid3;
    logic        z_ready3;
    logic [1:0]  z_ch3;

    int errors;
    int checks;

    stream_mux_rr #(.N(4), .WIDTH(8), .BURST(2), .SEL_W(2)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .s       (s),
        .a       (a),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .z       (z),
        .z_valid (z_valid),
        .z_ready (z_ready),
        .z_ch    (z_ch)
    );

    stream_mux_rr #(.N(3), .WIDTH(8), .BURST(2), .SEL_W(2)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode3),
        .s       (s3),
        .a       (a3),
        .a_valid (a_valid3),
        .a_ready (a_ready3),
        .z       (z3),
        .z_valid (z_valid3),
        .z_ready (z_ready3),
        .z_ch    (z_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] exp_z, input logic [1:0] exp_ch);
        step();
        chk({tag, " z"}, 32'(z), 32'(exp_z));
        chk({tag, " z_ch"}, 32'(z_ch), 32'(exp_ch));
        chk({tag, " z_valid"}, 32'(z_valid), 32'd1);
    endtask

    task automatic beat3(input string tag, input logic [1:0] exp_ch);
        step();
        chk({tag, " z_ch3"}, 32'(z_ch3), 32'(exp_ch));
        chk({tag, " z_valid3"}, 32'(z_valid3), 32'd1);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        mode     = 1'b0;
        s        = 2'd2;
        a        = {8'h44, 8'h33, 8'h22, 8'h11};
        a_valid  = 4'b1111;
        z_ready  = 1'b1;
        mode3    = 1'b0;
        s3       = 2'd0;
        a3       = {8'h33, 8'h22, 8'h11};
        a_valid3 = 3'b000;
        z_ready3 = 1'b1;

        // Reset state, a_ready gated while rst is high
        step();
        chk("rst z", 32'(z), 32'h0);
        chk("rst z_valid", 32'(z_valid), 32'h0);
        chk("rst z_ch", 32'(z_ch), 32'h0);
        chk("rst a_ready", 32'(a_ready), 32'h0);
        step();
        rst = 1'b0;

        // 1. Fixed select
        #1;
        chk("fix a_ready", 32'(a_ready), 32'b0100);
        beat("fix1", 8'h33, 2'd2);
        chk("fix a_ready2", 32'(a_ready), 32'b0100);
        beat("fix2", 8'h33, 2'd2);

        // 2. Round-robin with burst of 2
        mode = 1'b1;
        #1;
        chk("rr a_ready", 32'(a_ready), 32'b0001);
        beat("rr1", 8'h11, 2'd0);
        beat("rr2", 8'h11, 2'd0);
        beat("rr3", 8'h22, 2'd1);
        beat("rr4", 8'h22, 2'd1);
        beat("rr5", 8'h33, 2'd2);
        beat("rr6", 8'h33, 2'd2);
        beat("rr7", 8'h44, 2'd3);
        beat("rr8", 8'h44, 2'd3);
        beat("rr9", 8'h11, 2'd0);

        // 3. Backpressure while locked on channel 0 with cnt=1
        z_ready = 1'b0;
        #1;
        chk("bp a_ready", 32'(a_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            beat("bp hold", 8'h11, 2'd0);
            chk("bp a_ready hold", 32'(a_ready), 32'h0);
        end
        a[7:0]  = 8'h55;
        z_ready = 1'b1;
        #1;
        chk("bp resume a_ready", 32'(a_ready), 32'b0001);
        beat("bp next0", 8'h55, 2'd0);
        beat("bp next1", 8'h22, 2'd1);

        // 6. Reset mid-stream with z=22 and burst locked on channel 1
        rst = 1'b1;
        #1;
        chk("mid rst a_ready", 32'(a_ready), 32'h0);
        step();
        chk("mid rst z", 32'(z), 32'h0);
        chk("mid rst z_valid", 32'(z_valid), 32'h0);
        chk("mid rst z_ch", 32'(z_ch), 32'h0);
        rst     = 1'b0;
        a_valid = 4'b1100;
        #1;
        chk("post rst a_ready", 32'(a_ready), 32'b0100);
        beat("post rst", 8'h33, 2'd2);
        a_valid = 4'b0000;
        #1;
        chk("idle a_ready", 32'(a_ready), 32'h0);
        step();
        chk("idle drain z_valid", 32'(z_valid), 32'h0);
        chk("idle hold z_ch", 32'(z_ch), 32'd2);
        chk("idle hold z", 32'(z), 32'h33);

        // 4. Idle release: ptr=3 grants ch1, release moves ptr to 2, ch3 beats ch0
        a_valid = 4'b0010;
        #1;
        chk("ir a_ready1", 32'(a_ready), 32'b0010);
        beat("ir ch1", 8'h22, 2'd1);
        a_valid = 4'b1001;
        #1;
        chk("ir release a_ready", 32'(a_ready), 32'h0);
        step();
        chk("ir release z_valid", 32'(z_valid), 32'h0);
        chk("ir a_ready3", 32'(a_ready), 32'b1000);
        beat("ir ch3", 8'h44, 2'd3);

        // 5. N=3 build: out-of-range select and mode switch mid-burst
        a_valid3 = 3'b111;
        #1;
        chk("n3 a_ready s0", 32'(a_ready3), 32'b001);
        beat3("n3 fix", 2'd0);
        chk("n3 fix z3", 32'(z3), 32'h11);
        s3 = 2'd3;
        #1;
        chk("n3 oor a_ready", 32'(a_ready3), 32'h0);
        step();
        chk("n3 oor drain", 32'(z_valid3), 32'h0);
        chk("n3 oor z3 hold", 32'(z3), 32'h11);
        mode3 = 1'b1;
        #1;
        chk("n3 rr a_ready", 32'(a_ready3), 32'b001);
        beat3("n3 rr1", 2'd0);
        beat3("n3 rr2", 2'd0);
        beat3("n3 rr3", 2'd1);
        mode3 = 1'b0;
        #1;
        chk("n3 sw0 a_ready", 32'(a_ready3), 32'h0);
        step();
        chk("n3 sw0 drain", 32'(z_valid3), 32'h0);
        mode3 = 1'b1;
        #1;
        chk("n3 sw1 a_ready", 32'(a_ready3), 32'b010);
        beat3("n3 resume1", 2'd1);
        beat3("n3 resume2", 2'd1);
        beat3("n3 resume3", 2'd2);
        chk("n3 resume z3", 32'(z3), 32'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
